// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp controller: FSM states, register map,
// default timing constants and the pulse clamp helper.
package servo_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_MOVE,
        ST_EMIT,
        ST_DONE
    } servo_state_t;

    localparam logic [7:0] ADDR_TARGET = 8'h00;
    localparam logic [7:0] ADDR_STEP   = 8'h04;
    localparam logic [7:0] ADDR_CUR    = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;

    localparam int unsigned DEF_PERIOD        = 2000000;
    localparam int unsigned DEF_PULSE_MIN     = 50000;
    localparam int unsigned DEF_PULSE_MAX     = 250000;
    localparam int unsigned DEF_PULSE_NEUTRAL = 150000;
    localparam logic [19:0] DEF_STEP          = 20'd1000;

    function automatic logic [31:0] clamp_pulse(
        input logic [31:0] value,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/servo_ramp_step.sv
// Combinational saturating step: moves cur toward tgt by at most step and
// never past tgt.
module servo_ramp_step (
    input  logic [31:0] i_cur,
    input  logic [31:0] i_tgt,
    input  logic [31:0] i_step,
    output logic [31:0] o_next_cur,
    output logic        o_at_target
);

    logic        w_up;
    logic [31:0] w_dist;
    logic [31:0] w_delta;

    assign w_up        = (i_tgt >= i_cur);
    assign w_dist      = w_up ? (i_tgt - i_cur) : (i_cur - i_tgt);
    // Limiting the delta to the distance keeps the add/subtract in range.
    assign w_delta     = (i_step < w_dist) ? i_step : w_dist;
    assign o_next_cur  = w_up ? (i_cur + w_delta) : (i_cur - w_delta);
    assign o_at_target = (i_cur == i_tgt);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo ramp controller: steps a committed pulse width toward a bus-written
// target once per PERIOD and forwards each step to the downstream servo.
// Optional register readback is enabled with SERVO_RAMP_READBACK_EN.
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD        = DEF_PERIOD,
    parameter int unsigned PULSE_MIN     = DEF_PULSE_MIN,
    parameter int unsigned PULSE_MAX     = DEF_PULSE_MAX,
    parameter int unsigned PULSE_NEUTRAL = DEF_PULSE_NEUTRAL
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        bus_write_en,
    input  logic        ramp_sel,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_write_data,
    input  logic        bus_read_en,
    output logic [31:0] bus_read_data,
    output logic        servo_wr_en,
    output logic        servo_sel,
    output logic [31:0] servo_wdata,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] MIN_W     = 32'(PULSE_MIN);
    localparam logic [31:0] MAX_W     = 32'(PULSE_MAX);
    localparam logic [31:0] NEUTRAL_W = 32'(PULSE_NEUTRAL);
    localparam logic [31:0] LAST_CNT  = 32'(PERIOD - 1);

    servo_state_t r_state;
    logic [31:0]  r_cur;
    logic [31:0]  r_tgt;
    logic [31:0]  r_cnt;
    logic [19:0]  r_step;
    logic         r_wr_en;
    logic         r_busy;
    logic         r_done;

    logic         w_wr;
    logic         w_tgt_wr;
    logic         w_step_wr;
    logic         w_tick;
    logic         w_at_target;
    logic [31:0]  w_step_eff;
    logic [31:0]  w_next_cur;

    assign w_wr       = bus_write_en & ramp_sel;
    assign w_tgt_wr   = w_wr && (bus_addr == ADDR_TARGET);
    assign w_step_wr  = w_wr && (bus_addr == ADDR_STEP);
    assign w_tick     = (r_cnt == LAST_CNT);
    assign w_step_eff = (r_step == '0) ? 32'd1 : {12'd0, r_step};

    servo_ramp_step u_step (
        .i_cur       (r_cur),
        .i_tgt       (r_tgt),
        .i_step      (w_step_eff),
        .o_next_cur  (w_next_cur),
        .o_at_target (w_at_target)
    );

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            r_tgt  <= NEUTRAL_W;
            r_step <= DEF_STEP;
        end else begin
            if (w_tgt_wr)
                r_tgt <= clamp_pulse(bus_write_data, MIN_W, MAX_W);
            if (w_step_wr)
                r_step <= bus_write_data[19:0];
        end
    end

    // The period counter only runs in MOVE, so EMIT adds one cycle per step.
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_cur   <= NEUTRAL_W;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_wr_en <= 1'b1;
                    r_cnt   <= '0;
                    if (w_tgt_wr) begin
                        r_state <= ST_MOVE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_tgt_wr) begin
                        r_state <= ST_MOVE;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_MOVE: begin
                    if (w_tick) begin
                        r_cur   <= w_next_cur;
                        r_cnt   <= '0;
                        r_wr_en <= 1'b1;
                        r_state <= ST_EMIT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_EMIT: begin
                    // A fresh target here must not be lost by finishing early.
                    if (w_tgt_wr || !w_at_target) begin
                        r_state <= ST_MOVE;
                    end else begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_tgt_wr) begin
                        r_state <= ST_MOVE;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign servo_wr_en = r_wr_en;
    assign servo_sel   = r_wr_en;
    assign servo_wdata = r_cur;
    assign busy        = r_busy;
    assign done        = r_done;

`ifdef SERVO_RAMP_READBACK_EN
    logic w_rd;
    logic r_done_sticky;

    assign w_rd = bus_read_en & ramp_sel;

    // A completion coinciding with a status read stays visible for the next read.
    always_ff @(posedge pclk) begin
        if (!nreset)
            r_done_sticky <= 1'b0;
        else if (r_done)
            r_done_sticky <= 1'b1;
        else if (w_rd && (bus_addr == ADDR_STATUS))
            r_done_sticky <= 1'b0;
    end

    always_comb begin
        bus_read_data = '0;
        if (w_rd) begin
            case (bus_addr)
                ADDR_TARGET: bus_read_data = r_tgt;
                ADDR_STEP:   bus_read_data = {12'd0, r_step};
                ADDR_CUR:    bus_read_data = r_cur;
                ADDR_STATUS: bus_read_data = {30'd0, r_done_sticky, r_busy};
                default:     bus_read_data = '0;
            endcase
        end
    end
`else
    logic w_unused_rd;

    assign w_unused_rd   = bus_read_en;
    assign bus_read_data = '0;
`endif

endmodule
